tnn_frame_loader: RTL and testbench

Sequential front end for the combinational TNN classifiers. Accepts one FEAT_BITS-wide feature per beat over a valid/ready stream and packs a full frame into the classifier's parallel `features` bus. Holds that bus stable for a fixed settle window, captures the classifier's `prediction`, and returns it over a valid/ready result stream with a frame-length error flag. One instance sits between the sample source and each generated classifier netlist.

---
 rtl/tnn_frame_loader.sv | 120 ++++++++++++
 tb/tb_tnn_frame_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_frame_loader.sv
// Streams one frame of features into the classifier's parallel bus, holds it while the
// combinational classifier settles, then returns the captured class over a valid/ready stream.
`timescale 1ns/1ps
module tnn_frame_loader #(
  parameter int FEAT_CNT      = 128,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 6,
  parameter int SETTLE_CYCLES = 2,
  localparam int PRED_W = $clog2(CLASS_CNT),
  localparam int IDX_W  = $clog2(FEAT_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PRED_W-1:0]             prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PRED_W-1:0]             out_class,
  output logic                          out_error,
  output logic [15:0]                   frame_cnt
);

  typedef enum logic [1:0] {LOAD, SETTLE, HOLD} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FEAT_CNT - 1);

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [FEAT_CNT*FEAT_BITS-1:0]   features_q, features_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic                            out_valid_q, out_valid_d;
  logic [PRED_W-1:0]               out_class_q, out_class_d;
  logic                            out_error_q, out_error_d;
  logic [15:0]                     frame_cnt_q, frame_cnt_d;

  // Decoded from registered state only; held low while reset is asserted.
  assign in_ready  = (state_q == LOAD) && !rst;
  assign features  = features_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_error = out_error_q;
  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      features_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_error_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      features_q  <= features_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_error_q <= out_error_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    features_d  = features_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_error_d = out_error_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          features_d[idx_q*FEAT_BITS +: FEAT_BITS] = in_data;
          // A frame ends on whichever comes first: the last slot or in_last.
          if (idx_q == IDX_LAST || in_last) begin
            state_d = SETTLE;
            cnt_d   = 8'(SETTLE_CYCLES - 1);
            err_d   = !(idx_q == IDX_LAST && in_last);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          out_class_d = prediction;
          out_error_d = err_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          features_d  = '0;
          idx_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_tnn_frame_loader.sv
// Randomized bench for tnn_frame_loader: a frame-level model feeds a scoreboard that a
// separate monitor drains on every result handshake.
`timescale 1ns/1ps
module tb_tnn_frame_loader;
  localparam int FEAT_CNT  = 128;
  localparam int FEAT_BITS = 4;
  localparam int CLASS_CNT = 6;
  localparam int SETTLE    = 2;
  localparam int PW        = $clog2(CLASS_CNT);
  localparam int FW        = FEAT_CNT * FEAT_BITS;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_data = '0;
  logic            in_last = 1'b0;
  logic [FW-1:0]   features;
  logic [PW-1:0]   prediction;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [PW-1:0]   out_class;
  logic            out_error;
  logic [15:0]     frame_cnt;

  logic            toggle_en = 1'b0;
  logic [PW-1:0]   tog_q = '0;

  typedef struct {
    logic [PW-1:0] cls;
    logic          err;
    logic [FW-1:0] frame;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] m_frame [FEAT_CNT];
  int   m_n = 0;

  tnn_frame_loader #(
    .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .CLASS_CNT(CLASS_CNT), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .features(features), .prediction(prediction), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_error(out_error), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tog_q <= tog_q + 1'b1;

  // Classifier stub: weighted feature sum mod CLASS_CNT, or a free-running junk value.
  function automatic logic [PW-1:0] classify(input logic [FW-1:0] f);
    int s;
    s = 0;
    for (int k = 0; k < FEAT_CNT; k++) s += int'(f[k*FEAT_BITS +: FEAT_BITS]) * (k + 1);
    return PW'(s % CLASS_CNT);
  endfunction

  assign prediction = toggle_en ? tog_q : classify(features);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end else
      $display("ok   %s value=%0h t=%0t", name, act, $time);
  endtask

  task automatic chk_feat(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else
      $display("ok   %s t=%0t", name, $time);
  endtask

  function automatic logic [FW-1:0] model_packed();
    logic [FW-1:0] p;
    p = '0;
    for (int k = 0; k < FEAT_CNT; k++) p[k*FEAT_BITS +: FEAT_BITS] = m_frame[k];
    return p;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < FEAT_CNT; k++) m_frame[k] = '0;
    m_n = 0;
  endtask

  // Frame rules: fills slots in order, ends at FEAT_CNT beats or in_last; error unless both coincide.
  task automatic model_beat(input logic [3:0] d, input bit last, output bit done);
    exp_t e;
    m_frame[m_n] = d;
    m_n++;
    done = (m_n == FEAT_CNT) || last;
    if (done) begin
      e.frame = model_packed();
      e.cls   = classify(e.frame);
      e.err   = !(m_n == FEAT_CNT && last);
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input bit last, input int idle);
    int  w;
    int  slot;
    bit  done;
    in_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_last = last;
    w = 0;
    while (!in_ready && w < 1000) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    slot = m_n;
    model_beat(d, last, done);
    if (!done || slot != 0) chk("slot_visible", features[slot*FEAT_BITS +: FEAT_BITS], d);
    if (done) begin
      for (int i = 1; i <= SETTLE + 1; i++) begin
        @(negedge clk);
        chk("valid_timing", out_valid, (i == SETTLE + 1));
      end
    end
  endtask

  function automatic int sparse_idle();
    int n;
    n = 0;
    while ($urandom_range(99) >= 30 && n < 12) n++;
    return n;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_error", out_error, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk_feat("rst_features", features, '0);
    model_clear();
    @(negedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  int hs_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_cnt = 0;
        sb.delete();
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_class", out_class, e.cls);
          chk("out_error", out_error, e.err);
          chk_feat("frame_bus", features, e.frame);
          @(negedge clk);
          hs_cnt++;
          chk("frame_cnt", frame_cnt, 16'(hs_cnt));
          chk("ready_after_hs", in_ready, 1);
          chk_feat("cleared_bus", features, '0);
        end
      end
    end
  end

  initial begin
    logic [PW-1:0] hold_cls;
    logic          hold_err;
    int            len;
    int            w;
    model_clear();
    #1 rst = 1'b1;
    #1;
    chk("init_in_ready", in_ready, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_out_class", out_class, 0);
    chk("init_out_error", out_error, 0);
    chk("init_frame_cnt", frame_cnt, 0);
    chk_feat("init_features", features, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready, 1);
    out_ready = 1'b1;

    // Full dense frame, k mod 16
    for (int k = 0; k < FEAT_CNT; k++) send_beat(4'(k % 16), (k == FEAT_CNT - 1), 0);
    // Short frame of 10 x 0xF
    for (int k = 0; k < 10; k++) send_beat(4'hF, (k == 9), 0);
    // Long frame: 128 beats without in_last, then 5 more ending with in_last
    for (int k = 0; k < FEAT_CNT; k++) send_beat(4'($urandom), 1'b0, 0);
    for (int k = 0; k < 5; k++) send_beat(4'($urandom), (k == 4), 0);

    // Backpressure with a toggling stub prediction during HOLD
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < FEAT_CNT; k++) send_beat(4'($urandom), (k == FEAT_CNT - 1), 0);
    hold_cls = out_class;
    hold_err = out_error;
    toggle_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_class", out_class, hold_cls);
      chk("bp_error", out_error, hold_err);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 toggle_en = 1'b0;

    // Sparse (~30% duty) frames: the k mod 16 pattern, then random-length frames
    for (int k = 0; k < FEAT_CNT; k++) send_beat(4'(k % 16), (k == FEAT_CNT - 1), sparse_idle());
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, FEAT_CNT);
      for (int k = 0; k < len; k++) send_beat(4'($urandom), (k == len - 1), sparse_idle());
    end

    // Drain before the reset scenarios
    w = 0;
    while (sb.size() != 0 && w < 1000) begin @(posedge clk); w++; end
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame at beat 60, then reset while a result is pending in HOLD
    for (int k = 0; k < 60; k++) send_beat(4'($urandom), 1'b0, 0);
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < FEAT_CNT; k++) send_beat(4'($urandom), (k == FEAT_CNT - 1), 0);
    do_reset();
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < FEAT_CNT; k++) send_beat(4'($urandom), (k == FEAT_CNT - 1), 0);

    w = 0;
    while (sb.size() != 0 && w < 1000) begin @(posedge clk); w++; end
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_frame_cnt", frame_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
